// File: rtl/wavecap_axi_if.sv
// rtl/wavecap_axi_if.sv - AXI4-Lite bundle between a host master and the wavecap slave
interface wavecap_axi_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/wavecap_axi.sv
// rtl/wavecap_axi.sv - triggered two-channel waveform capture with decimation
// Registers and capture buffer are reachable through an AXI4-Lite slave.
module wavecap_axi #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 12,
  parameter int CAPTURE_DEPTH        = 256
) (
  input  logic               s00_axi_aclk,
  input  logic               s00_axi_aresetn,
  input  logic signed [15:0] in_a,
  input  logic signed [15:0] in_b,
  input  logic               sample_en,
  input  logic               trig_in,
  output logic               done_irq,
  wavecap_axi_if.slave       s00_axi
);
  localparam int         IW        = $clog2(CAPTURE_DEPTH);
  localparam logic [8:0] DEPTH_CNT = 9'(CAPTURE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  logic                            awready_q, wready_q, bvalid_q;
  logic                            arready_q, rd_pend_q, rvalid_q;
  logic [9:0]                      raddr_q;
  logic [C_S00_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic signed [15:0]              trig_level_q;
  logic [15:0]                     decim_q, dec_cnt_q;
  logic [1:0]                      tsrc_q;
  state_t                          state_q;
  logic [8:0]                      count_q;
  logic                            done_q;
  logic signed [15:0]              prev_a_q;
  logic                            trig_prev_q;
  logic [31:0]                     buf_mem [CAPTURE_DEPTH];

  logic          wr_en, ctrl_wr, arm, abort, trig_hit, store_en;
  logic [9:0]    waddr;
  logic [IW-1:0] store_idx;

  assign waddr   = s00_axi.awaddr[11:2];
  assign wr_en   = awready_q;
  assign ctrl_wr = wr_en && (waddr == 10'd0) && s00_axi.wstrb[0];
  assign arm     = ctrl_wr && s00_axi.wdata[0];
  assign abort   = ctrl_wr && s00_axi.wdata[1];

  always_comb begin
    trig_hit = 1'b0;
    if (sample_en) begin
      case (tsrc_q)
        2'd1:    trig_hit = (prev_a_q < trig_level_q) && (in_a >= trig_level_q);
        2'd2:    trig_hit = trig_in && !trig_prev_q;
        default: trig_hit = 1'b1;
      endcase
    end
  end

  // The triggering sample itself lands in BUF[0]; later stores follow the decimator.
  assign store_en = !abort && sample_en &&
                    (((state_q == S_ARMED) && trig_hit) ||
                     ((state_q == S_CAPTURE) && (count_q != DEPTH_CNT) && (dec_cnt_q == decim_q)));
  assign store_idx = (state_q == S_CAPTURE) ? count_q[IW-1:0] : '0;

  always_ff @(posedge s00_axi_aclk) begin
    if (store_en) buf_mem[store_idx] <= {in_b, in_a};
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      if (s00_axi.awvalid && s00_axi.wvalid && !bvalid_q && !awready_q) begin
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
      end
      if (awready_q)           bvalid_q <= 1'b1;
      else if (s00_axi.bready) bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      trig_level_q <= '0;
      decim_q      <= '0;
      tsrc_q       <= '0;
    end else if (wr_en) begin
      case (waddr)
        10'd0: if (s00_axi.wstrb[0]) tsrc_q <= s00_axi.wdata[5:4];
        10'd2: begin
          if (s00_axi.wstrb[0]) trig_level_q[7:0]  <= s00_axi.wdata[7:0];
          if (s00_axi.wstrb[1]) trig_level_q[15:8] <= s00_axi.wdata[15:8];
        end
        10'd3: begin
          if (s00_axi.wstrb[0]) decim_q[7:0]  <= s00_axi.wdata[7:0];
          if (s00_axi.wstrb[1]) decim_q[15:8] <= s00_axi.wdata[15:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      dec_cnt_q   <= '0;
      done_q      <= 1'b0;
      prev_a_q    <= '0;
      trig_prev_q <= 1'b0;
    end else begin
      if (sample_en) begin
        prev_a_q    <= in_a;
        trig_prev_q <= trig_in;
      end
      if (abort) begin
        state_q <= S_IDLE;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (arm) begin
              state_q <= S_ARMED;
              count_q <= '0;
              done_q  <= 1'b0;
            end
          end
          S_ARMED: begin
            if (trig_hit) begin
              state_q   <= S_CAPTURE;
              count_q   <= 9'd1;
              dec_cnt_q <= '0;
            end
          end
          S_CAPTURE: begin
            if (count_q == DEPTH_CNT) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (sample_en) begin
              if (dec_cnt_q == decim_q) begin
                count_q   <= count_q + 9'd1;
                dec_cnt_q <= '0;
              end else begin
                dec_cnt_q <= dec_cnt_q + 16'd1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (raddr_q[9]) begin
      if ({1'b0, raddr_q[8:0]} < 10'(CAPTURE_DEPTH)) rdata_d = buf_mem[raddr_q[IW-1:0]];
    end else begin
      case (raddr_q[8:0])
        9'd1:    rdata_d = {23'd0, done_q, 6'd0, state_q};
        9'd2:    rdata_d = {16'd0, trig_level_q};
        9'd3:    rdata_d = {16'd0, decim_q};
        9'd4:    rdata_d = {23'd0, count_q};
        default: rdata_d = '0;
      endcase
    end
  end

  // Two-stage read: latch the address, then register the selected word.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      arready_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      raddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      arready_q <= 1'b0;
      if (s00_axi.arvalid && !arready_q && !rd_pend_q && !rvalid_q) arready_q <= 1'b1;
      rd_pend_q <= arready_q;
      if (arready_q) raddr_q <= s00_axi.araddr[11:2];
      if (rd_pend_q) begin
        rdata_q  <= rdata_d;
        rvalid_q <= 1'b1;
      end else if (s00_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = wready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = 2'b00;
  assign done_irq        = done_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0],
                       s00_axi.araddr[1:0], s00_axi.wdata[31:16], s00_axi.wstrb[3:2]};
endmodule

// File: tb/tb_wavecap_axi.sv
// tb/tb_wavecap_axi.sv - directed bench for wavecap_axi with a read scoreboard
module tb_wavecap_axi;
  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic signed [15:0] in_a = '0;
  logic signed [15:0] in_b = '0;
  logic               sample_en = 1'b0;
  logic               trig_in = 1'b0;
  logic               done_irq;

  wavecap_axi_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) axi ();

  wavecap_axi #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(12),
    .CAPTURE_DEPTH(256)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(rstn),
    .in_a(in_a),
    .in_b(in_b),
    .sample_en(sample_en),
    .trig_in(trig_in),
    .done_irq(done_irq),
    .s00_axi(axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int last_rd_lat = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.awready && n < 20);
    if (!axi.awready) check("aw_timeout", 32'(axi.awready), 32'd1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.bvalid && n < 20);
    if (!axi.bvalid) check("b_timeout", 32'(axi.bvalid), 32'd1);
    else check("bresp", 32'(axi.bresp), 32'd0);
    axi.bready = 1'b1;
    @(posedge clk); #1;
    axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    sb_t e;
    int  n;
    e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    axi.araddr = addr; axi.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.arready && n < 20);
    if (!axi.arready) check("ar_timeout", 32'(axi.arready), 32'd1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.rvalid && n < 20);
    last_rd_lat = n;
    e = sb_q.pop_front();
    if (!axi.rvalid) begin
      check({e.tag, "_timeout"}, 32'(axi.rvalid), 32'd1);
    end else begin
      check(e.tag, axi.rdata, e.exp);
      check("rresp", 32'(axi.rresp), 32'd0);
    end
    axi.rready = 1'b1;
    @(posedge clk); #1;
    axi.rready = 1'b0;
  endtask

  task automatic sample(input logic signed [15:0] a, input logic signed [15:0] b, input logic t);
    @(posedge clk); #1;
    in_a = a; in_b = b; trig_in = t; sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done_irq", 32'(done_irq), 32'd0);
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_rdata", axi.rdata, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    axi_read(12'h004, 32'h0000_0000, "status_reset");
    axi_read(12'h010, 32'h0000_0000, "count_reset");
    axi_read(12'h00C, 32'h0000_0000, "decim_reset");
    axi_write(12'h00C, 32'h0000_1234, 4'hF);
    axi_read(12'h00C, 32'h0000_1234, "decim_rw");
    check("rd_latency", 32'(last_rd_lat), 32'd2);
    axi_read(12'h014, 32'h0000_0000, "unmapped");
    axi_write(12'h008, 32'h0000_55AA, 4'h1);
    axi_read(12'h008, 32'h0000_00AA, "level_wstrb");
    axi_write(12'h010, 32'h0000_01FF, 4'hF);
    axi_read(12'h010, 32'h0000_0000, "count_ro");

    // Immediate trigger, full buffer, no decimation.
    axi_write(12'h00C, 32'h0, 4'hF);
    axi_write(12'h000, 32'h1, 4'hF);
    axi_read(12'h004, 32'h0000_0001, "status_armed");
    for (int k = 0; k < 256; k++) sample(16'(k), 16'(-k), 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("full_done_irq", 32'(done_irq), 32'd1);
    axi_read(12'h004, 32'h0000_0103, "status_done");
    axi_read(12'h010, 32'h0000_0100, "count_full");
    axi_read(12'h814, 32'hFFFB_0005, "buf5");
    axi_read(12'h800, 32'h0000_0000, "buf0");
    axi_read(12'hBFC, 32'hFF01_00FF, "buf255");
    axi_read(12'hC00, 32'h0000_0000, "buf_out_of_range");
    sample(16'sd7, 16'sd7, 1'b0);
    axi_read(12'h800, 32'h0000_0000, "buf0_no_write_in_done");

    // Level trigger on a rising in_a ramp.
    axi_write(12'h008, 32'd100, 4'hF);
    axi_write(12'h000, 32'h11, 4'hF);
    sample(16'sd0, 16'sd0, 1'b0);
    sample(16'sd50, 16'sd0, 1'b0);
    axi_read(12'h004, 32'h0000_0001, "level_not_yet");
    for (int k = 2; k < 10; k++) sample(16'(50 * k), 16'sd0, 1'b0);
    axi_read(12'h800, 32'h0000_0064, "level_buf0");
    axi_read(12'h804, 32'h0000_0096, "level_buf1");
    axi_read(12'h010, 32'h0000_0008, "level_count");

    // Abort mid-capture, with ARM written alongside.
    sample(16'sd500, 16'sd0, 1'b0);
    sample(16'sd550, 16'sd0, 1'b0);
    axi_write(12'h000, 32'h3, 4'hF);
    @(negedge clk);
    check("abort_done_irq", 32'(done_irq), 32'd0);
    axi_read(12'h004, 32'h0000_0000, "abort_status");
    axi_read(12'h010, 32'h0000_000A, "abort_count");
    axi_write(12'h000, 32'h1, 4'hF);
    axi_read(12'h010, 32'h0000_0000, "rearm_count");
    axi_read(12'h004, 32'h0000_0001, "rearm_status");

    // Decimation by 4 with immediate trigger.
    axi_write(12'h00C, 32'd3, 4'hF);
    for (int k = 0; k < 13; k++) sample(16'(k), 16'sd0, 1'b0);
    axi_read(12'h804, 32'h0000_0004, "decim_buf1");
    axi_read(12'h808, 32'h0000_0008, "decim_buf2");
    axi_read(12'h010, 32'h0000_0004, "decim_count");

    // External trigger edge.
    axi_write(12'h000, 32'h2, 4'hF);
    axi_write(12'h00C, 32'h0, 4'hF);
    axi_write(12'h000, 32'h21, 4'hF);
    sample(16'sd1, 16'sd0, 1'b0);
    axi_read(12'h004, 32'h0000_0001, "ext_not_yet");
    sample(16'sd2, 16'sd0, 1'b1);
    sample(16'sd3, 16'sd0, 1'b1);
    axi_read(12'h004, 32'h0000_0002, "ext_capture");
    axi_read(12'h800, 32'h0000_0002, "ext_buf0");
    axi_read(12'h010, 32'h0000_0002, "ext_count");

    // Reset during capture with a write response outstanding.
    @(posedge clk); #1;
    axi.awaddr = 12'h00C; axi.awvalid = 1'b1;
    axi.wdata = 32'h55; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.awready && n < 20);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.bvalid && n < 20);
    check("pre_rst_bvalid", 32'(axi.bvalid), 32'd1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check("async_rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("async_rst_state", {30'd0, dut.state_q}, 32'd0);
    check("async_rst_done_irq", 32'(done_irq), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    axi_read(12'h004, 32'h0000_0000, "post_rst_status");
    axi_read(12'h00C, 32'h0000_0000, "post_rst_decim");
    axi_read(12'h010, 32'h0000_0000, "post_rst_count");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wavecap_axi.md
WAVECAP_AXI -- requirements
Module: wavecap_axi

Interface
REQ-001 Parameter C_S00_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S00_AXI_ADDR_WIDTH, default 12, AXI4-Lite byte address width.
REQ-003 Parameter CAPTURE_DEPTH, default 256, number of sample words in the buffer; power of two, maximum 256.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 s00_axi_aclk  in  1  sole clock; all logic on the rising edge.
REQ-006 s00_axi_aresetn  in  1  asynchronous active-low reset.
REQ-007 in_a, in_b  in  16 each  signed waveform samples from the generator.
REQ-008 sample_en  in  1  one-cycle strobe marking a new sample on in_a/in_b.
REQ-009 trig_in  in  1  external trigger, synchronous to s00_axi_aclk.
REQ-010 done_irq  out  1  high while the state is DONE.
REQ-011 s00_axi_aw*/w*/b*/ar*/r* ports are standard AXI4-Lite slave signals; prot inputs are ignored.

Function
REQ-012 The register map SHALL be as follows:
- 0x00 CTRL (W): bit0 ARM (self-clearing); bit1 ABORT (self-clearing); bits[5:4] TSRC, where 0 = immediate, 1 = in_a rising level, 2 = trig_in rising edge, 3 = immediate.
- 0x04 STATUS (RO): [1:0] state, where IDLE=0, ARMED=1, CAPTURE=2, DONE=3; bit8 = done.
- 0x08 TRIG_LEVEL (RW, [15:0], signed).
- 0x0C DECIM (RW, [15:0]).
- 0x10 COUNT (RO, [8:0]).
- 0x800 + 4*i: BUF[i] (RO) = {in_b, in_a} for i < CAPTURE_DEPTH.
REQ-013 Write channel:
- awready and wready SHALL pulse together for one cycle when awvalid, wvalid and !bvalid all hold.
- bvalid SHALL rise the next cycle and hold until bready; bresp SHALL always be 00.
REQ-014 wstrb SHALL gate RW registers bytewise; writes to RO or unmapped addresses SHALL be ignored with an OKAY response.
REQ-015 Read channel:
- arready SHALL pulse for one cycle when arvalid, !rvalid and no read is pending.
- rvalid SHALL rise exactly 2 cycles after the accept cycle and hold with stable rdata until rready; rresp SHALL be 00.
REQ-016 Unmapped reads and BUF indices at or above CAPTURE_DEPTH SHALL return 0.
REQ-017 Reads and writes SHALL be served concurrently and independently.
REQ-018 FSM transitions:
- IDLE -> ARMED on ARM, which also clears COUNT and the done bit.
- ARMED -> CAPTURE on the trigger.
- CAPTURE -> DONE when COUNT == CAPTURE_DEPTH.
- DONE -> ARMED on ARM.
- Any state -> IDLE on ABORT; COUNT is retained.
REQ-019 ARM SHALL be ignored in ARMED and CAPTURE; if ARM and ABORT are written together, ABORT SHALL win.
REQ-020 Triggers SHALL be evaluated only on sample_en cycles:
- TSRC=1: previous in_a < TRIG_LEVEL and current in_a >= TRIG_LEVEL (signed compare); the previous sample SHALL be tracked in all states.
- TSRC=2: trig_in high and trig_in low on the prior sample_en.
- TSRC=0/3: the first sample_en while ARMED.
REQ-021 The triggering sample SHALL be stored as BUF[0] in the same cycle the FSM enters CAPTURE.
REQ-022 Decimation during CAPTURE:
- A counter SHALL count sample_en cycles and store one sample every DECIM+1 strobes.
- DECIM=0 stores every sample; the counter SHALL reset on the trigger.
REQ-023 Each store SHALL write BUF[COUNT] and increment COUNT by 1; COUNT saturates at CAPTURE_DEPTH and no write occurs past it.
REQ-024 An AXI read of BUF colliding with a store in the same cycle SHALL return either the old or new word, with no stall.
REQ-025 sample_en pulses outside CAPTURE SHALL NOT write the buffer.

Reset
REQ-026 On s00_axi_aresetn low, the following SHALL be cleared asynchronously: state to IDLE, COUNT=0, TRIG_LEVEL=0, DECIM=0, TSRC=0, done_irq=0, and all of awready, wready, bvalid, arready, rvalid, rdata to 0.
REQ-027 BUF contents SHALL be undefined after reset.
REQ-028 Reset asserted mid-transaction or mid-capture SHALL abandon the activity; the first AXI handshake is accepted in the cycle after reset releases.

Verification
REQ-029 The bench SHALL cover: write 0x0C=0x00001234, then read 0x0C -> 0x00001234; read 0x14 -> 0x00000000, bresp/rresp 00, rvalid 2 cycles after arready.
REQ-030 The bench SHALL cover: TSRC=0, DECIM=0, ARM, then 256 sample_en with in_a=k, in_b=-k -> DONE, done_irq=1, COUNT=256, BUF[5]=0xFFFB0005.
REQ-031 The bench SHALL cover: TSRC=1, TRIG_LEVEL=100, ramp in_a 0,50,...; the trigger fires at in_a=100 -> BUF[0][15:0]=100.
REQ-032 The bench SHALL cover: DECIM=3, in_a=k per strobe from trigger k=0 -> BUF[1][15:0]=4, BUF[2][15:0]=8.
REQ-033 The bench SHALL cover: ABORT after 10 stored samples -> STATUS=0x00000000, COUNT=10, done_irq=0; a later ARM clears COUNT to 0.
REQ-034 The bench SHALL cover: reset asserted during CAPTURE with bvalid pending -> bvalid=0 and state IDLE immediately, without waiting for a clock edge.
